// File: rtl/inference_stream_pkg.sv
// Shared types and constants for the inference stream adapter: FSM states,
// the default fixed-point format and the index-width helper.
package inference_stream_pkg;

  localparam int FX_W            = 25;
  localparam int FX_NFRAC        = 16;
  localparam int DEF_INPUT_SIZE  = 16;
  localparam int DEF_OUTPUT_SIZE = 5;

  typedef logic signed [FX_W-1:0] fx_t;

  localparam fx_t ONE_FX = fx_t'(1) << FX_NFRAC;

  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_DRAIN
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/inference_stream_adapter_result_serializer.sv
// Captures the core's parallel scores (optionally clamping negatives to 1.0)
// and replays them one word per valid/ready handshake with a last marker.
module result_serializer
  import inference_stream_pkg::*;
#(
  parameter int WIDTH       = FX_W,
  parameter int NFRAC       = FX_NFRAC,
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  parameter int CLAMP_NEG   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_capture,
  input  logic signed [WIDTH-1:0] i_scores [OUTPUT_SIZE],
  input  logic                    i_out_ready,
  output logic signed [WIDTH-1:0] o_out_data,
  output logic                    o_out_valid,
  output logic                    o_out_last,
  output logic                    o_done
);

  localparam int OIW = idx_w(OUTPUT_SIZE);
  localparam logic [OIW-1:0] LAST_IDX = OIW'(OUTPUT_SIZE - 1);
  localparam logic signed [WIDTH-1:0] ONE =
    (WIDTH == FX_W && NFRAC == FX_NFRAC) ? WIDTH'(ONE_FX) : (WIDTH'(1) << NFRAC);

  logic signed [WIDTH-1:0] r_res [OUTPUT_SIZE];
  logic signed [WIDTH-1:0] r_data;
  logic [OIW-1:0]          r_idx;
  logic                    r_valid;
  logic                    w_beat;

  function automatic logic signed [WIDTH-1:0] clamp_score(input logic signed [WIDTH-1:0] s);
    if (CLAMP_NEG != 0 && s[WIDTH-1]) return ONE;
    return s;
  endfunction

  assign w_beat      = r_valid && i_out_ready;
  assign o_out_last  = r_valid && (r_idx == LAST_IDX);
  assign o_done      = w_beat && o_out_last;
  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;

  // Capture stage; out_data is preloaded so it is a pure register output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      for (int k = 0; k < OUTPUT_SIZE; k++) r_res[k] <= '0;
    end else if (i_capture) begin
      for (int k = 0; k < OUTPUT_SIZE; k++) r_res[k] <= clamp_score(i_scores[k]);
      r_data  <= clamp_score(i_scores[0]);
      r_valid <= 1'b1;
      r_idx   <= '0;
    end else if (w_beat) begin
      if (r_idx == LAST_IDX) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
        r_data <= r_res[r_idx + 1'b1];
      end
    end
  end

endmodule

// File: rtl/inference_stream_adapter.sv
// Streams feature words into the jet-tagging core, fires it, waits for its
// result edge (with timeout) and streams the class scores back out.
module inference_stream_adapter
  import inference_stream_pkg::*;
#(
  parameter int WIDTH       = FX_W,
  parameter int NFRAC       = FX_NFRAC,
  parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  parameter int CLAMP_NEG   = 1,
  parameter int TIMEOUT     = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] core_input_data [INPUT_SIZE],
  output logic                    core_input_ready,
  input  logic                    core_output_ready,
  input  logic signed [WIDTH-1:0] core_output_data [OUTPUT_SIZE],
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [31:0]             infer_count
);

  localparam int IIW = idx_w(INPUT_SIZE);
  localparam logic [IIW-1:0] LAST_IN  = IIW'(INPUT_SIZE - 1);
  localparam logic [31:0]    TMO_LAST = 32'(TIMEOUT - 1);

  state_t                  r_state;
  logic [IIW-1:0]          r_idx;
  logic [31:0]             r_tmo;
  logic [31:0]             r_count;
  logic                    r_rdy_q;
  logic                    r_start;
  logic                    r_tmo_err;
  logic signed [WIDTH-1:0] r_feat [INPUT_SIZE];
  logic                    w_accept;
  logic                    w_capture;
  logic                    w_done;

  assign in_ready         = !reset && (r_state == S_LOAD);
  assign w_accept         = in_valid && in_ready;
  // Edge-qualified so a level left high by the previous inference is ignored
  assign w_capture        = (r_state == S_WAIT) && core_output_ready && !r_rdy_q;
  assign busy             = (r_state != S_LOAD) || (r_idx != '0);
  assign core_input_data  = r_feat;
  assign core_input_ready = r_start;
  assign timeout_err      = r_tmo_err;
  assign infer_count      = r_count;

  // Control stage: load packer, start pulse, result wait with timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_idx     <= '0;
      r_tmo     <= '0;
      r_count   <= '0;
      r_rdy_q   <= 1'b0;
      r_start   <= 1'b0;
      r_tmo_err <= 1'b0;
      for (int k = 0; k < INPUT_SIZE; k++) r_feat[k] <= '0;
    end else begin
      r_rdy_q <= core_output_ready;
      r_start <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_feat[r_idx] <= in_data;
            if (r_idx == LAST_IN) begin
              r_idx   <= '0;
              r_start <= 1'b1;
              r_state <= S_FIRE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_FIRE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_capture) begin
            r_state <= S_DRAIN;
          end else if (TIMEOUT != 0 && r_tmo == TMO_LAST) begin
            r_tmo_err <= 1'b1;
            r_state   <= S_LOAD;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        S_DRAIN: begin
          if (w_done) begin
            r_count <= r_count + 32'd1;
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  result_serializer #(
    .WIDTH       (WIDTH),
    .NFRAC       (NFRAC),
    .OUTPUT_SIZE (OUTPUT_SIZE),
    .CLAMP_NEG   (CLAMP_NEG)
  ) u_ser (
    .clk         (clk),
    .reset       (reset),
    .i_capture   (w_capture),
    .i_scores    (core_output_data),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .o_out_last  (out_last),
    .o_done      (w_done)
  );

endmodule

// File: tb/tb_inference_stream_adapter.sv
// Directed bench: a clamping and a passthrough adapter driven in lockstep,
// with a hand-sequenced core response and hand-computed expected words.
module tb_inference_stream_adapter;

  localparam int W   = 25;
  localparam int NI  = 16;
  localparam int NO  = 5;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic core_output_ready = 1'b0;
  logic signed [W-1:0] core_output_data [NO];
  logic out_ready = 1'b1;

  logic in_ready, core_input_ready, out_valid, out_last, busy, timeout_err;
  logic signed [W-1:0] core_input_data [NI];
  logic signed [W-1:0] out_data;
  logic [31:0] infer_count;

  logic in_ready_n, core_input_ready_n, out_valid_n, out_last_n, busy_n, timeout_err_n;
  logic signed [W-1:0] core_input_data_n [NI];
  logic signed [W-1:0] out_data_n;
  logic [31:0] infer_count_n;

  logic signed [W-1:0] exp_c [NO];
  logic signed [W-1:0] exp_n [NO];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inference_stream_adapter #(.WIDTH(W), .NFRAC(16), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO),
                             .CLAMP_NEG(1), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_input_data(core_input_data), .core_input_ready(core_input_ready),
    .core_output_ready(core_output_ready), .core_output_data(core_output_data),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err), .infer_count(infer_count)
  );

  inference_stream_adapter #(.WIDTH(W), .NFRAC(16), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO),
                             .CLAMP_NEG(0), .TIMEOUT(TMO)) u_dut_nc (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_n),
    .core_input_data(core_input_data_n), .core_input_ready(core_input_ready_n),
    .core_output_ready(core_output_ready), .core_output_data(core_output_data),
    .out_data(out_data_n), .out_valid(out_valid_n), .out_last(out_last_n), .out_ready(out_ready),
    .busy(busy_n), .timeout_err(timeout_err_n), .infer_count(infer_count_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input int base);
    int g;
    for (int k = 0; k < n; k++) begin
      g = 0;
      while (!in_ready && g < 40) begin
        tick();
        g++;
      end
      if (!in_ready) check("feed_in_ready", in_ready, 1);
      in_data  = W'(base + k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input bit bp, input bit lat, input bit chk_n);
    int beat;
    int cyc;
    int first_v;
    beat = 0;
    cyc = 0;
    first_v = -1;
    while (beat < NO && cyc < 80) begin
      out_ready = bp ? ((cyc - 1) % 3 == 0) : 1'b1;
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        check({tag, "_data"}, out_data, exp_c[beat]);
        check({tag, "_last"}, out_last, beat == NO - 1);
        if (chk_n) check({tag, "_nc_data"}, out_data_n, exp_n[beat]);
        beat++;
      end else if (out_valid) begin
        check({tag, "_hold"}, out_data, exp_c[beat]);
        check({tag, "_stall_in_ready"}, in_ready, 0);
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    check({tag, "_beats"}, beat, NO);
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
    if (lat) begin
      check({tag, "_valid_latency"}, first_v, 1);
      check({tag, "_drain_cycles"}, cyc, NO + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    for (int k = 0; k < NO; k++) core_output_data[k] = '0;

    // reset state
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_start", core_input_ready, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_infer_count", infer_count, 0);
    check("rst_data0", core_input_data[0], 0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);

    // basic run
    feed(NI, 1);
    check("basic_start", core_input_ready, 1);
    check("basic_fire_in_ready", in_ready, 0);
    check("basic_fire_busy", busy, 1);
    for (int k = 0; k < NI; k++) check("basic_feature", core_input_data[k], k + 1);
    tick();
    check("basic_single_pulse", core_input_ready, 0);
    repeat (6) tick();
    core_output_data = '{25'sh04000, 25'sh08000, 25'sh10000, 25'sh02000, 25'sh02000};
    exp_c = '{25'sh04000, 25'sh08000, 25'sh10000, 25'sh02000, 25'sh02000};
    core_output_ready = 1'b1;
    collect("basic", 1'b0, 1'b1, 1'b0);
    check("basic_count", infer_count, 1);
    core_output_ready = 1'b0;
    tick();

    // negative clamp vs passthrough
    feed(NI, 100);
    repeat (4) tick();
    core_output_data = '{-25'sd3, 25'sh0C000, 25'sd0, -25'sh10000, 25'sd5};
    exp_c = '{25'sh10000, 25'sh0C000, 25'sd0, 25'sh10000, 25'sd5};
    exp_n = '{-25'sd3, 25'sh0C000, 25'sd0, -25'sh10000, 25'sd5};
    core_output_ready = 1'b1;
    collect("clamp", 1'b0, 1'b0, 1'b1);
    check("clamp_count", infer_count, 2);
    core_output_ready = 1'b0;
    tick();

    // backpressure; output_ready is then left high into the next inference
    feed(NI, 200);
    repeat (4) tick();
    core_output_data = '{25'sh00111, 25'sh00222, 25'sh00333, 25'sh00444, 25'sh00555};
    exp_c = '{25'sh00111, 25'sh00222, 25'sh00333, 25'sh00444, 25'sh00555};
    core_output_ready = 1'b1;
    collect("bp", 1'b1, 1'b0, 1'b0);
    check("bp_count", infer_count, 3);

    // sticky output_ready: only a fresh low->high edge captures
    feed(NI, 300);
    check("sticky_start", core_input_ready, 1);
    core_output_data = '{25'sh01000, 25'sh02000, 25'sh03000, 25'sh04000, 25'sh05000};
    exp_c = '{25'sh01000, 25'sh02000, 25'sh03000, 25'sh04000, 25'sh05000};
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen = seen | out_valid;
    end
    check("sticky_no_capture", seen, 0);
    core_output_ready = 1'b0;
    tick();
    core_output_ready = 1'b1;
    collect("sticky", 1'b0, 1'b1, 1'b0);
    check("sticky_count", infer_count, 4);
    core_output_ready = 1'b0;
    tick();

    // timeout with a silent core
    feed(NI, 400);
    check("tmo_start", core_input_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | out_valid;
    end
    check("tmo_not_early", timeout_err, 0);
    tick();
    seen = seen | out_valid;
    check("tmo_err_set", timeout_err, 1);
    check("tmo_in_ready", in_ready, 1);
    check("tmo_no_output", seen, 0);
    check("tmo_count_kept", infer_count, 4);
    tick();
    check("tmo_err_sticky", timeout_err, 1);

    // reset in the middle of a load
    feed(9, 500);
    check("rml_busy_partial", busy, 1);
    reset = 1'b1;
    tick();
    check("rml_in_ready_rst", in_ready, 0);
    check("rml_err_cleared", timeout_err, 0);
    check("rml_count_cleared", infer_count, 0);
    check("rml_busy_cleared", busy, 0);
    check("rml_data_cleared", core_input_data[8], 0);
    reset = 1'b0;
    tick();
    check("rml_in_ready", in_ready, 1);
    feed(7, 600);
    seen = core_input_ready;
    repeat (3) begin
      tick();
      seen = seen | core_input_ready;
    end
    check("rml_no_early_start", seen, 0);
    feed(9, 607);
    check("rml_start", core_input_ready, 1);
    check("rml_first_word", core_input_data[0], 600);
    check("rml_last_word", core_input_data[15], 615);

    // passthrough instance tracked the same control sequence
    check("nc_start", core_input_ready_n, 1);
    check("nc_in_ready", in_ready_n, 0);
    check("nc_busy", busy_n, 1);
    check("nc_err", timeout_err_n, 0);
    check("nc_count", infer_count_n, 0);
    check("nc_valid", out_valid_n, 0);
    check("nc_last", out_last_n, 0);
    check("nc_word", core_input_data_n[15], 615);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
